// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter
// Description : Two-master Wishbone B4 arbiter. Round-robin grant per cyc
//               window, no preemption. Optional slave-response timeout is
//               enabled by defining WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 256
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // master 0 (instruction cache)
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    input  logic [SW-1:0] i_m0_sel,
    input  logic [2:0]    i_m0_cti,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_data,
    // master 1 (data cache)
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    input  logic [SW-1:0] i_m1_sel,
    input  logic [2:0]    i_m1_cti,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_data,
    // slave side
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [SW-1:0] o_wb_sel,
    output logic [2:0]    o_wb_cti,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;
    logic   w_own_cyc;
    logic   w_own_stb;
    logic   w_timeout;
    logic   w_abort;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("wb_bus_arbiter: TIMEOUT must be within 2..65535");
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == GRANT0) begin
                r_last <= 1'b0;
            end else if (r_state == IDLE && w_next == GRANT1) begin
                r_last <= 1'b1;
            end
        end
    end

    // A grant is only released when its owner drops cyc; a tie goes to the
    // master that did not own the bus last.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_next = r_last ? GRANT0 : GRANT1;
                end else if (i_m0_cyc) begin
                    w_next = GRANT0;
                end else if (i_m1_cyc) begin
                    w_next = GRANT1;
                end
            end
            GRANT0:  if (!i_m0_cyc) w_next = IDLE;
            GRANT1:  if (!i_m1_cyc) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        o_wb_cti  = 3'b000;
        if (r_state == GRANT0 && i_m0_cyc) begin
            w_own_cyc = 1'b1;
            w_own_stb = i_m0_stb;
            o_wb_cyc  = 1'b1;
            o_wb_stb  = i_m0_stb;
            o_wb_we   = i_m0_we;
            o_wb_addr = i_m0_addr;
            o_wb_data = i_m0_data;
            o_wb_sel  = i_m0_sel;
            o_wb_cti  = i_m0_cti;
        end else if (r_state == GRANT1 && i_m1_cyc) begin
            w_own_cyc = 1'b1;
            w_own_stb = i_m1_stb;
            o_wb_cyc  = 1'b1;
            o_wb_stb  = i_m1_stb;
            o_wb_we   = i_m1_we;
            o_wb_addr = i_m1_addr;
            o_wb_data = i_m1_data;
            o_wb_sel  = i_m1_sel;
            o_wb_cti  = i_m1_cti;
        end
        if (w_abort) begin
            o_wb_cyc = 1'b0;
            o_wb_stb = 1'b0;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic        r_abort;
    logic        w_strobing;

    assign w_strobing = w_own_cyc & w_own_stb & ~r_abort;
    assign w_timeout  = w_strobing & ~i_wb_ack & ~i_wb_err & (r_to_cnt == c_TIMEOUT_LAST);
    assign w_abort    = r_abort;

    // Every grant change passes through IDLE, which clears the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= 16'd0;
            r_abort  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_to_cnt <= 16'd0;
            r_abort  <= 1'b0;
        end else begin
            if (i_wb_ack || i_wb_err || w_timeout) begin
                r_to_cnt <= 16'd0;
            end else if (w_strobing) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_abort <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_abort   = 1'b0;
`endif

    assign o_m0_ack  = (r_state == GRANT0) & i_wb_ack;
    assign o_m1_ack  = (r_state == GRANT1) & i_wb_ack;
    assign o_m0_err  = (r_state == GRANT0) & (i_wb_err | w_timeout);
    assign o_m1_err  = (r_state == GRANT1) & (i_wb_err | w_timeout);
    assign o_m0_data = i_wb_data;
    assign o_m1_data = i_wb_data;
    assign o_grant   = {r_state == GRANT1, r_state == GRANT0};

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_arbiter
// Description : Directed self-checking bench for wb_bus_arbiter (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic [2:0]  m0_cti, m1_cti;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [31:0] wb_addr, wb_wdata, wb_rdata;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.DW(32), .AW(32), .SW(4), .TIMEOUT(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_wdata), .i_m0_sel(m0_sel), .i_m0_cti(m0_cti),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_data(m0_rdata),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_wdata), .i_m1_sel(m1_sel), .i_m1_cti(m1_cti),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_data(m1_rdata),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .o_wb_sel(wb_sel), .o_wb_cti(wb_cti),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1000;
        m0_wdata = 32'h0; m0_sel = 4'hF; m0_cti = 3'b000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_2000;
        m1_wdata = 32'h0; m1_sel = 4'hF; m1_cti = 3'b000;
        wb_ack = 1'b1; wb_err = 1'b0; wb_rdata = 32'h0;

        // reset held with both masters requesting
        #3;
        chk("rst_grant", grant, 2'b00);
        chk("rst_wb_cyc", wb_cyc, 1'b0);
        chk("rst_wb_stb", wb_stb, 1'b0);
        chk("rst_wb_addr", wb_addr, 32'h0);
        chk("rst_m0_ack", m0_ack, 1'b0);
        chk("rst_m1_ack", m1_ack, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; wb_ack = 1'b0;
        nxt(); #1;
        chk("tie_grant", grant, 2'b01);
        chk("tie_wb_cyc", wb_cyc, 1'b1);
        chk("tie_wb_addr", wb_addr, 32'h0000_1000);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        nxt(); nxt(); #1;
        chk("idle_grant", grant, 2'b00);

        // single read by m0
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_1000;
        #1;
        chk("rd_latency_cyc", wb_cyc, 1'b0);
        nxt(); #1;
        chk("rd_grant", grant, 2'b01);
        chk("rd_wb_cyc", wb_cyc, 1'b1);
        chk("rd_wb_addr", wb_addr, 32'h0000_1000);
        chk("rd_wb_sel", wb_sel, 4'hF);
        nxt(); #1;
        chk("rd_noack", m0_ack, 1'b0);
        wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_m0_ack", m0_ack, 1'b1);
        chk("rd_m0_data", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_ack", m1_ack, 1'b0);
        nxt();
        m0_cyc = 1'b0; m0_stb = 1'b0; wb_ack = 1'b0;
        #1;
        chk("rd_drop_cyc", wb_cyc, 1'b0);
        chk("rd_drop_grant", grant, 2'b01);
        nxt(); #1;
        chk("rd_idle", grant, 2'b00);

        // 4-beat burst by m0, m1 requests during the burst
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_cti = 3'b010; m0_addr = 32'h100;
        nxt();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_2000;
        m1_wdata = 32'hCAFE_0001; m1_sel = 4'h3;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt();
            m0_addr = 32'h100 + 32'(k * 4);
            m0_cti = (k == 3) ? 3'b111 : 3'b010;
            wb_ack = 1'b1;
            #1;
            chk("burst_grant", grant, 2'b01);
            chk("burst_m0_ack", m0_ack, 1'b1);
            chk("burst_m1_ack", m1_ack, 1'b0);
            chk("burst_addr", wb_addr, 32'h100 + 32'(k * 4));
            chk("burst_cti", wb_cti, (k == 3) ? 3'b111 : 3'b010);
        end
        nxt();
        m0_cyc = 1'b0; m0_stb = 1'b0; wb_ack = 1'b0;
        #1;
        chk("burst_drop_grant", grant, 2'b01);
        chk("burst_drop_cyc", wb_cyc, 1'b0);
        nxt(); #1;
        chk("burst_dead", grant, 2'b00);
        nxt(); #1;
        chk("burst_m1_grant", grant, 2'b10);
        chk("m1_wb_we", wb_we, 1'b1);
        chk("m1_wb_addr", wb_addr, 32'h0000_2000);
        chk("m1_wb_data", wb_wdata, 32'hCAFE_0001);
        chk("m1_wb_sel", wb_sel, 4'h3);

        // error pass-through on m1 write
        wb_err = 1'b1;
        #1;
        chk("err_m1_err", m1_err, 1'b1);
        chk("err_m0_err", m0_err, 1'b0);
        chk("err_m1_ack", m1_ack, 1'b0);
        nxt();
        wb_err = 1'b0;
        #1;
        chk("err_hold_grant", grant, 2'b10);
        chk("err_pulse_end", m1_err, 1'b0);
        chk("err_hold_cyc", wb_cyc, 1'b1);
        nxt();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        #1;
        chk("err_drop_grant", grant, 2'b10);
        nxt(); #1;
        chk("err_idle", grant, 2'b00);

        // round-robin with both masters always requesting
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_cti = 3'b000; m1_cyc = 1'b1; m1_stb = 1'b1;
        wb_ack = 1'b1;
        #1;
        chk("rr_idle_ack", m0_ack, 1'b0);
        for (int r = 0; r < 4; r++) begin
            nxt(); #1;
            chk("rr_grant", grant, r[0] ? 2'b10 : 2'b01);
            chk("rr_owner_ack", r[0] ? m1_ack : m0_ack, 1'b1);
            chk("rr_other_ack", r[0] ? m0_ack : m1_ack, 1'b0);
            nxt();
            if (r[0]) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
            else      begin m0_cyc = 1'b0; m0_stb = 1'b0; end
            #1;
            chk("rr_drop_cyc", wb_cyc, 1'b0);
            nxt();
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
            #1;
            chk("rr_dead", grant, 2'b00);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; wb_ack = 1'b0;
        nxt();

        // cyc without stb keeps the grant; then a strobe the slave never acks
        m0_cyc = 1'b1; m0_stb = 1'b0; m0_addr = 32'h0000_3000;
        nxt(); #1;
        chk("nostb_grant", grant, 2'b01);
        chk("nostb_cyc", wb_cyc, 1'b1);
        chk("nostb_stb", wb_stb, 1'b0);
        m0_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        for (int s = 1; s <= 8; s++) begin
            if (s > 1) nxt();
            #1;
            chk("to_err", m0_err, (s == 8) ? 1'b1 : 1'b0);
            chk("to_cyc", wb_cyc, 1'b1);
        end
        nxt(); #1;
        chk("to_abort_cyc", wb_cyc, 1'b0);
        chk("to_abort_stb", wb_stb, 1'b0);
        chk("to_abort_err", m0_err, 1'b0);
        chk("to_abort_grant", grant, 2'b01);
`else
        for (int s = 1; s <= 100; s++) begin
            if (s > 1) nxt();
            #1;
            chk("noto_err", m0_err, 1'b0);
            chk("noto_cyc", wb_cyc, 1'b1);
        end
`endif
        m0_cyc = 1'b0; m0_stb = 1'b0;
        nxt(); #1;
        chk("to_idle", grant, 2'b00);

        // asynchronous reset in the middle of an m1 cycle
        m1_cyc = 1'b1; m1_stb = 1'b1;
        nxt(); #1;
        chk("ar_grant", grant, 2'b10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_grant_clr", grant, 2'b00);
        chk("ar_cyc_clr", wb_cyc, 1'b0);
        chk("ar_addr_clr", wb_addr, 32'h0);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nxt(); #1;
        chk("ar_idle", grant, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
